dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-cache port between two requesters:
  - the load path: load-queue entries whose address is already resolved;
  - the committed-store path: the store buffer draining retired stores.
- Allows one outstanding cache transaction at a time.
- Loads have priority by default. A starvation counter and an urgency input keep the store buffer from stalling retirement.
- Sits between the LSQ and the dmem interface of the memory subsystem. It also handles pipeline flush for in-flight loads.

Parameters:
- STARVE_LIMIT, 4: consecutive load grants allowed while a store waits; after that the next grant is forced to the store.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (reset when 0)
- flush  in  1  pipeline flush; kills the in-flight or requesting load
- ld_req  in  1  load request valid
- ld_addr  in  32  word-aligned load address
- ld_mask  in  4  load byte mask, nonzero
- ld_ready  out  1  load request accepted this cycle
- ld_resp_valid  out  1  load data valid, one-cycle pulse
- ld_rdata  out  32  load data
- st_req  in  1  committed-store request valid
- st_addr  in  32  word-aligned store address
- st_mask  in  4  store byte mask, nonzero
- st_wdata  in  32  store data
- st_urgent  in  1  store buffer at its high-water mark
- st_ready  out  1  store request accepted this cycle
- st_done  out  1  store write acknowledged, one-cycle pulse
- dmem_addr  out  32  cache address
- dmem_rmask  out  4  cache read mask; nonzero means read in progress
- dmem_wmask  out  4  cache write mask; nonzero means write in progress
- dmem_wdata  out  32  cache write data
- dmem_rdata  in  32  cache read data
- dmem_resp  in  1  cache response, one-cycle pulse

Behaviour:
- Reset values:
  - state = IDLE;
  - starve_cnt = 0;
  - dmem_rmask = 0, dmem_wmask = 0;
  - dmem_addr = 0, dmem_wdata = 0;
  - ld_resp_valid = 0, st_done = 0.
  - Reset mid-transaction abandons the transaction; a later dmem_resp with state = IDLE is ignored.
- States:
  - IDLE: no transaction outstanding.
  - WAIT_LD: load outstanding.
  - WAIT_LD_KILL: load outstanding, but flushed.
  - WAIT_ST: store outstanding.
- Grant window: cycles where state = IDLE, or where dmem_resp = 1 in any WAIT state. This gives back-to-back issue.
- Grant selection inside the grant window:
  - Store is selected if st_req = 1 and any of: ld_req = 0, flush = 1, st_urgent = 1, or starve_cnt >= STARVE_LIMIT.
  - Otherwise the load is selected if ld_req = 1 and flush = 0.
- ld_ready and st_ready are combinational and one-hot. Each is asserted only in the grant window and only for the selected requester. The handshake is complete in the cycle ready = 1 with req = 1.
- Issue latency: a grant at cycle t puts registered dmem_addr and masks on the port at t+1. Transition targets:
  - load grant → WAIT_LD;
  - store grant → WAIT_ST, with dmem_wdata = st_wdata;
  - no grant on a response cycle → IDLE, masks cleared at t+1.
- Port hold: dmem_rmask/dmem_wmask stay stable and nonzero from issue through the dmem_resp cycle inclusive. Exactly one of the two masks is nonzero at any time.
- Load response: dmem_resp in WAIT_LD gives ld_resp_valid = 1 and ld_rdata = dmem_rdata, both registered and visible the next cycle.
- Flush of an outstanding load:
  - flush in WAIT_LD without dmem_resp → WAIT_LD_KILL.
  - dmem_resp in WAIT_LD_KILL, or dmem_resp in the same cycle as flush, suppresses ld_resp_valid. The port still completes the transaction.
- Stores are never affected by flush.
- Store response: dmem_resp in WAIT_ST gives st_done = 1 the next cycle.
- starve_cnt:
  - increments (saturating at STARVE_LIMIT) on each load grant while st_req = 1;
  - clears on a store grant;
  - is held otherwise.
- dmem_resp in IDLE is ignored.

Test Plan:
1. Reset: hold rst = 0 for 2 cycles, driving dmem_resp = 1 → all masks 0, no ld_resp_valid, no st_done, ld_ready = 1 when ld_req is set after reset.
2. Single load: ld_req, ld_addr = 0x00001000, ld_mask = 0xF at t0 → ld_ready at t0; dmem_rmask = 0xF, dmem_addr = 0x1000 at t1; dmem_resp with rdata 0xDEADBEEF at t3 → ld_resp_valid with 0xDEADBEEF at t4.
3. Starvation: ld_req and st_req held continuously, 1-cycle cache latency, STARVE_LIMIT = 4 → grant pattern L,L,L,L,S repeating; back-to-back issue with no IDLE gap.
4. Urgency: both requesting, st_urgent = 1, starve_cnt = 0 → store granted first; dmem_wmask = st_mask, dmem_wdata = st_wdata; st_done one cycle after resp.
5. Flush: load outstanding, flush at t2, resp at t4 → no ld_resp_valid; pending st_req granted on the t4 resp cycle.
6. Flush while requesting: ld_req and flush in IDLE with st_req = 0 → ld_ready = 0, ports stay idle; same cycle with st_req = 1 → store granted.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - arbitrates the single data-cache port between the load path and the store buffer
module dmem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_mask,
    output logic        ld_ready,
    output logic        ld_resp_valid,
    output logic [31:0] ld_rdata,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [3:0]  st_mask,
    input  logic [31:0] st_wdata,
    input  logic        st_urgent,
    output logic        st_ready,
    output logic        st_done,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] WAIT_LD      = 2'd1;
    localparam logic [1:0] WAIT_LD_KILL = 2'd2;
    localparam logic [1:0] WAIT_ST      = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             grant_window;
    logic             sel_st;
    logic             sel_ld;

    // A response cycle is also a grant cycle so the port can issue back-to-back.
    assign starved      = (starve_cnt >= CNT_W'(STARVE_LIMIT));
    assign grant_window = (state == IDLE) || dmem_resp;
    assign sel_st       = st_req && (!ld_req || flush || st_urgent || starved);
    assign sel_ld       = ld_req && !flush && !sel_st;
    assign st_ready     = rst && grant_window && sel_st;
    assign ld_ready     = rst && grant_window && sel_ld;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            dmem_addr     <= '0;
            dmem_rmask    <= '0;
            dmem_wmask    <= '0;
            dmem_wdata    <= '0;
            ld_resp_valid <= 1'b0;
            ld_rdata      <= '0;
            st_done       <= 1'b0;
        end else begin
            // A flush arriving with the response still kills the load data.
            ld_resp_valid <= (state == WAIT_LD) && dmem_resp && !flush;
            st_done       <= (state == WAIT_ST) && dmem_resp;
            if ((state == WAIT_LD) && dmem_resp) begin
                ld_rdata <= dmem_rdata;
            end

            if (ld_ready) begin
                state      <= WAIT_LD;
                dmem_addr  <= ld_addr;
                dmem_rmask <= ld_mask;
                dmem_wmask <= '0;
                if (st_req && !starved) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (st_ready) begin
                state      <= WAIT_ST;
                dmem_addr  <= st_addr;
                dmem_rmask <= '0;
                dmem_wmask <= st_mask;
                dmem_wdata <= st_wdata;
                starve_cnt <= '0;
            end else if ((state != IDLE) && dmem_resp) begin
                state      <= IDLE;
                dmem_rmask <= '0;
                dmem_wmask <= '0;
            end else if ((state == WAIT_LD) && flush) begin
                state <= WAIT_LD_KILL;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter with randomized traffic
module tb_dmem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [3:0]  ld_mask = 4'hF;
    logic        ld_ready;
    logic        ld_resp_valid;
    logic [31:0] ld_rdata;
    logic        st_req = 1'b0;
    logic [31:0] st_addr = '0;
    logic [3:0]  st_mask = 4'hF;
    logic [31:0] st_wdata = '0;
    logic        st_urgent = 1'b0;
    logic        st_ready;
    logic        st_done;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_resp = 1'b0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_mask(ld_mask), .ld_ready(ld_ready),
        .ld_resp_valid(ld_resp_valid), .ld_rdata(ld_rdata),
        .st_req(st_req), .st_addr(st_addr), .st_mask(st_mask), .st_wdata(st_wdata),
        .st_urgent(st_urgent), .st_ready(st_ready), .st_done(st_done),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    typedef struct {
        bit          is_st;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } txn_t;

    txn_t        port_q[$];
    logic [31:0] ld_q[$];
    bit          st_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_ld_grant = 0;
    int          n_st_grant = 0;

    // Reference model: one outstanding transaction, loads first unless the store has waited too long.
    bit m_busy = 0, m_is_st = 0, m_killed = 0;
    int m_starve = 0;
    bit m_win, m_sel_st, exp_ld, exp_st;
    txn_t t;

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            m_busy = 0; m_killed = 0; m_starve = 0;
            port_q.delete(); ld_q.delete(); st_q.delete();
        end else begin
            m_win    = !m_busy || dmem_resp;
            m_sel_st = st_req && (!ld_req || flush || st_urgent || m_starve >= 4);
            exp_st   = m_win && m_sel_st;
            exp_ld   = m_win && !m_sel_st && ld_req && !flush;
            checks++;
            if (ld_ready !== exp_ld || st_ready !== exp_st) begin
                errors++;
                $display("FAIL ready: got ld=%b st=%b, expected ld=%b st=%b at %0t",
                         ld_ready, st_ready, exp_ld, exp_st, $time);
            end
            if (ld_ready) n_ld_grant++;
            if (st_ready) n_st_grant++;
            if (m_busy && dmem_resp) begin
                if (m_is_st) st_q.push_back(1'b1);
                else if (!m_killed && !flush) ld_q.push_back(dmem_rdata);
                m_busy = 0;
            end else if (m_busy && !m_is_st && flush) begin
                m_killed = 1;
            end
            if (exp_ld) begin
                t = '{0, ld_addr, ld_mask, 32'h0};
                port_q.push_back(t);
                m_busy = 1; m_is_st = 0; m_killed = 0;
                if (st_req && m_starve < 4) m_starve++;
            end
            if (exp_st) begin
                t = '{1, st_addr, st_mask, st_wdata};
                port_q.push_back(t);
                m_busy = 1; m_is_st = 1; m_killed = 0;
                m_starve = 0;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the queued expectations.
    bit          was_rst_n = 0, prev_active = 0, prev_resp = 0, active;
    logic [3:0]  prev_rmask, prev_wmask;
    logic [31:0] prev_addr;
    txn_t        e;
    logic [31:0] er;
    bit          es;

    always @(negedge clk) begin
        active = (dmem_rmask != 0) || (dmem_wmask != 0);
        if (!was_rst_n) begin
            checks++;
            if (active || ld_resp_valid || st_done) begin
                errors++;
                $display("FAIL reset_state: rmask=%h wmask=%h ld_resp_valid=%b st_done=%b, expected all 0",
                         dmem_rmask, dmem_wmask, ld_resp_valid, st_done);
            end
            active = 0;
        end else begin
            if (active) begin
                checks++;
                if (dmem_rmask != 0 && dmem_wmask != 0) begin
                    errors++;
                    $display("FAIL one_mask: rmask=%h wmask=%h, expected only one nonzero", dmem_rmask, dmem_wmask);
                end
            end
            if (active && (!prev_active || prev_resp)) begin
                checks++;
                if (port_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue: unexpected transaction addr=%h rmask=%h wmask=%h", dmem_addr, dmem_rmask, dmem_wmask);
                end else begin
                    e = port_q.pop_front();
                    if (dmem_addr !== e.addr ||
                        dmem_rmask !== (e.is_st ? 4'h0 : e.mask) ||
                        dmem_wmask !== (e.is_st ? e.mask : 4'h0) ||
                        (e.is_st && dmem_wdata !== e.wdata)) begin
                        errors++;
                        $display("FAIL issue: got addr=%h rmask=%h wmask=%h wdata=%h, expected st=%b addr=%h mask=%h wdata=%h",
                                 dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, e.is_st, e.addr, e.mask, e.wdata);
                    end
                end
            end else if (active || prev_active) begin
                checks++;
                if (prev_active && !prev_resp &&
                    (dmem_rmask !== prev_rmask || dmem_wmask !== prev_wmask || dmem_addr !== prev_addr)) begin
                    errors++;
                    $display("FAIL port_hold: got addr=%h rmask=%h wmask=%h, expected addr=%h rmask=%h wmask=%h",
                             dmem_addr, dmem_rmask, dmem_wmask, prev_addr, prev_rmask, prev_wmask);
                end
                if (active && prev_active && prev_resp) begin
                    errors++;
                    $display("FAIL issue: port active after response with no grant, rmask=%h wmask=%h", dmem_rmask, dmem_wmask);
                end
            end
            if (ld_resp_valid) begin
                checks++;
                if (ld_q.size() == 0) begin
                    errors++;
                    $display("FAIL ld_resp: unexpected ld_resp_valid rdata=%h", ld_rdata);
                end else begin
                    er = ld_q.pop_front();
                    if (ld_rdata !== er) begin
                        errors++;
                        $display("FAIL ld_resp: got rdata=%h, expected %h", ld_rdata, er);
                    end
                end
            end
            if (st_done) begin
                checks++;
                if (st_q.size() == 0) begin
                    errors++;
                    $display("FAIL st_done: unexpected st_done pulse");
                end else begin
                    es = st_q.pop_front();
                end
            end
        end
        prev_active = active;
        prev_resp   = dmem_resp;
        prev_rmask  = dmem_rmask;
        prev_wmask  = dmem_wmask;
        prev_addr   = dmem_addr;
        was_rst_n   = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0; ld_req = 0; st_req = 0; flush = 0; st_urgent = 0; dmem_resp = 1;
        tick(); tick();
        rst = 1; dmem_resp = 0;
    endtask

    function automatic bit port_active();
        return (dmem_rmask != 0) || (dmem_wmask != 0);
    endfunction

    initial begin
        // Reset with a stray response pending, then a single directed load.
        do_reset();
        ld_req = 1; ld_addr = 32'h0000_1000; ld_mask = 4'hF;
        tick();
        ld_req = 0;
        tick();
        tick();
        dmem_resp = 1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_resp = 0;
        tick(); tick();

        // Both requesters saturated with a one-cycle cache: expect L,L,L,L,S back-to-back.
        do_reset();
        n_ld_grant = 0; n_st_grant = 0;
        for (int i = 0; i < 40; i++) begin
            ld_req = 1; st_req = 1;
            ld_addr = $urandom & 32'hFFFF_FFFC; ld_mask = 4'($urandom_range(1, 15));
            st_addr = $urandom & 32'hFFFF_FFFC; st_mask = 4'($urandom_range(1, 15)); st_wdata = $urandom;
            dmem_resp = port_active(); dmem_rdata = $urandom;
            tick();
        end
        ld_req = 0; st_req = 0;
        checks++;
        if (n_ld_grant != 32 || n_st_grant != 8) begin
            errors++;
            $display("FAIL starvation: got ld_grants=%0d st_grants=%0d, expected 32 and 8", n_ld_grant, n_st_grant);
        end
        dmem_resp = port_active();
        tick();
        dmem_resp = 0;

        // Urgent store beats a load with the counter at zero.
        do_reset();
        ld_req = 1; st_req = 1; st_urgent = 1;
        st_addr = 32'h0000_2004; st_mask = 4'h3; st_wdata = 32'h1234_5678;
        tick();
        ld_req = 0; st_req = 0; st_urgent = 0;
        dmem_resp = 1;
        tick();
        dmem_resp = 0;
        tick(); tick();

        // Flush of an outstanding load, store granted on the response cycle.
        ld_req = 1; ld_addr = 32'h0000_3000; ld_mask = 4'hF;
        tick();
        ld_req = 0;
        tick();
        flush = 1;
        tick();
        flush = 0;
        tick();
        st_req = 1; st_addr = 32'h0000_4000; st_mask = 4'hC; st_wdata = 32'hCAFE_0001;
        dmem_resp = 1; dmem_rdata = 32'hBAD0_BAD0;
        tick();
        st_req = 0; dmem_resp = 0;
        tick();
        dmem_resp = 1;
        tick();
        dmem_resp = 0;

        // Flush while a load is requesting in IDLE, without and with a store present.
        ld_req = 1; flush = 1;
        tick();
        st_req = 1; st_addr = 32'h0000_5000; st_mask = 4'h1; st_wdata = 32'h0000_00AA;
        tick();
        ld_req = 0; st_req = 0; flush = 0; dmem_resp = 1;
        tick();
        dmem_resp = 0;
        tick();

        // Randomized traffic with variable cache latency, stray responses and one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            rst       = (i != 1500);
            ld_req    = ($urandom % 4) != 0;
            st_req    = ($urandom % 2) != 0;
            st_urgent = ($urandom % 8) == 0;
            flush     = ($urandom % 10) == 0;
            ld_addr   = $urandom & 32'hFFFF_FFFC; ld_mask = 4'($urandom_range(1, 15));
            st_addr   = $urandom & 32'hFFFF_FFFC; st_mask = 4'($urandom_range(1, 15));
            st_wdata  = $urandom;
            dmem_rdata = $urandom;
            dmem_resp = port_active() ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
            tick();
        end

        rst = 1; ld_req = 0; st_req = 0; flush = 0; st_urgent = 0;
        for (int i = 0; i < 10; i++) begin
            dmem_resp = port_active();
            tick();
        end
        dmem_resp = 0;
        tick(); tick();

        checks++;
        if (port_q.size() != 0 || ld_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending issue=%0d ld_resp=%0d st_done=%0d, expected all 0",
                     port_q.size(), ld_q.size(), st_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
